// File: rtl/qam_frame_sequencer.sv
// Frame sequencer for the 16-QAM mapper: prepends a fixed preamble, splits payload
// bytes into HI/LO nibble symbols and produces the mapper start/valid/done strobes.
module qam_frame_sequencer #(
  parameter int          PREAMBLE_LEN = 4,
  parameter logic [3:0]  PREAMBLE_SYM = 4'hA
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic [7:0] frame_len,
  input  logic       frame_abort,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic       hold_i,
  output logic [3:0] symbol,
  output logic       sym_valid,
  output logic       qam_start,
  output logic       done_o,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_PREAMBLE = 3'd2,
    S_PAYLOAD  = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_LEN - 1);

  state_t     state_q,     state_d;
  logic [7:0] len_q,       len_d;
  logic [7:0] acc_cnt_q,   acc_cnt_d;
  logic [3:0] pre_cnt_q,   pre_cnt_d;
  logic [7:0] buf_q,       buf_d;
  logic       full_q,      full_d;
  logic       nib_q,       nib_d;       // 0 = HI nibble next, 1 = LO nibble next
  logic [3:0] symbol_q,    symbol_d;
  logic       sym_valid_q, sym_valid_d;
  logic       qam_start_q, qam_start_d;
  logic       done_q,      done_d;
  logic       busy_q,      busy_d;

  logic in_frame_s;
  logic ready_s;
  logic accept_s;
  logic issue_pay_s;
  logic last_nib_s;

  assign in_frame_s  = (state_q == S_START) || (state_q == S_PREAMBLE) || (state_q == S_PAYLOAD);
  // A full buffer may be refilled on the edge its LO nibble leaves, keeping 2 cycles/byte.
  assign ready_s     = in_frame_s && (acc_cnt_q < len_q) &&
                       (!full_q || (nib_q && !hold_i && (state_q == S_PAYLOAD)));
  assign accept_s    = byte_valid && ready_s;
  assign issue_pay_s = (state_q == S_PAYLOAD) && full_q && !hold_i;
  assign last_nib_s  = issue_pay_s && nib_q && (acc_cnt_q == len_q);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    acc_cnt_d   = acc_cnt_q;
    pre_cnt_d   = pre_cnt_q;
    buf_d       = buf_q;
    full_d      = full_q;
    nib_d       = nib_q;
    symbol_d    = symbol_q;
    sym_valid_d = 1'b0;
    qam_start_d = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d   = S_START;
          len_d     = frame_len;
          acc_cnt_d = 8'd0;
          pre_cnt_d = 4'd0;
          full_d    = 1'b0;
          nib_d     = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (PREAMBLE_LEN != 0) begin
          state_d = S_PREAMBLE;
        end else if (len_q != 8'd0) begin
          state_d = S_PAYLOAD;
        end else begin
          state_d = S_DONE;
        end
      end
      S_PREAMBLE: begin
        if (!hold_i) begin
          symbol_d    = PREAMBLE_SYM;
          sym_valid_d = 1'b1;
          pre_cnt_d   = pre_cnt_q + 4'd1;
          if (pre_cnt_q == PRE_LAST) begin
            state_d = (len_q == 8'd0) ? S_DONE : S_PAYLOAD;
          end else begin
            state_d = S_PREAMBLE;
          end
        end else begin
          state_d = S_PREAMBLE;
        end
      end
      S_PAYLOAD: begin
        if (issue_pay_s) begin
          symbol_d    = nib_q ? buf_q[3:0] : buf_q[7:4];
          sym_valid_d = 1'b1;
          nib_d       = ~nib_q;
          full_d      = ~nib_q;
          state_d     = last_nib_s ? S_DONE : S_PAYLOAD;
        end else begin
          state_d = S_PAYLOAD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (accept_s) begin
      buf_d     = byte_data;
      full_d    = 1'b1;
      acc_cnt_d = acc_cnt_q + 8'd1;
    end else begin
      buf_d = buf_d;
    end

    qam_start_d = (state_q == S_IDLE) && frame_start;
    // busy stays up through the done_o cycle.
    busy_d      = (state_d != S_IDLE) || (state_q == S_DONE);

    if (frame_abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      acc_cnt_d   = 8'd0;
      pre_cnt_d   = 4'd0;
      full_d      = 1'b0;
      nib_d       = 1'b0;
      symbol_d    = symbol_q;
      sym_valid_d = 1'b0;
      qam_start_d = 1'b0;
      done_d      = 1'b0;
      busy_d      = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      len_q       <= 8'd0;
      acc_cnt_q   <= 8'd0;
      pre_cnt_q   <= 4'd0;
      buf_q       <= 8'd0;
      full_q      <= 1'b0;
      nib_q       <= 1'b0;
      symbol_q    <= 4'd0;
      sym_valid_q <= 1'b0;
      qam_start_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      acc_cnt_q   <= acc_cnt_d;
      pre_cnt_q   <= pre_cnt_d;
      buf_q       <= buf_d;
      full_q      <= full_d;
      nib_q       <= nib_d;
      symbol_q    <= symbol_d;
      sym_valid_q <= sym_valid_d;
      qam_start_q <= qam_start_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign byte_ready = ready_s;
  assign symbol     = symbol_q;
  assign sym_valid  = sym_valid_q;
  assign qam_start  = qam_start_q;
  assign done_o     = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_qam_frame_sequencer.sv
// Directed bench for qam_frame_sequencer: a scoreboard queue holds the expected
// symbol stream and a monitor pops it on every sym_valid; frame timing is checked per frame.
module tb_qam_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start;
  logic       frame_start0;
  logic [7:0] frame_len;
  logic       frame_abort;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       hold_i;

  logic       byte_ready,  byte_ready0;
  logic [3:0] symbol,      symbol0;
  logic       sym_valid,   sym_valid0;
  logic       qam_start,   qam_start0;
  logic       done_o,      done_o0;
  logic       busy,        busy0;

  int         errors = 0;
  int         checks = 0;
  logic [3:0] exp_q[$];
  logic [3:0] mon_sym;
  logic [7:0] src[0:7];

  qam_frame_sequencer #(.PREAMBLE_LEN(4), .PREAMBLE_SYM(4'hA)) u_dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .frame_len(frame_len),
    .frame_abort(frame_abort), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .hold_i(hold_i), .symbol(symbol), .sym_valid(sym_valid),
    .qam_start(qam_start), .done_o(done_o), .busy(busy)
  );

  qam_frame_sequencer #(.PREAMBLE_LEN(0), .PREAMBLE_SYM(4'hA)) u_dut0 (
    .clk(clk), .rst(rst), .frame_start(frame_start0), .frame_len(frame_len),
    .frame_abort(frame_abort), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_ready(byte_ready0), .hold_i(hold_i), .symbol(symbol0), .sym_valid(sym_valid0),
    .qam_start(qam_start0), .done_o(done_o0), .busy(busy0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_syms(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(v[4*i +: 4]);
  endtask

  // Scoreboard monitor: every presented symbol must match the head of the expected queue.
  always begin
    @(posedge clk);
    #2;
    if (sym_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_symbol", int'(symbol), -1);
      end else begin
        mon_sym = exp_q.pop_front();
        chk("symbol", int'(symbol), int'(mon_sym));
      end
    end
  end

  // One frame of 20 edges, k = edge index after E0; kill_k aborts (or resets when kill_rst).
  task automatic run_frame(input logic [7:0] len, input int nbytes, input int hold_k,
                           input int drop_lo, input int drop_hi, input int kill_k,
                           input bit kill_rst, input int midfs_k, input int exp_done,
                           input int exp_nsym, input int exp_bytes, input int gap_k,
                           input string tag);
    int idx = 0, nsym = 0, ndone = 0, nqs = 0, k_done = -1, k_qs = -1, last_k = -1;
    bit saw_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      frame_start = (k == 0) || (k == midfs_k);
      frame_len   = (k == 0) ? len : 8'd7;
      hold_i      = (k == hold_k);
      frame_abort = (k == kill_k) && !kill_rst;
      rst         = !((k == kill_k) && kill_rst);
      byte_valid  = (idx < nbytes) && !((k >= drop_lo) && (k <= drop_hi)) && rst;
      byte_data   = (idx < nbytes) ? src[idx] : 8'h00;
      @(negedge clk);
      if (byte_ready) saw_ready = 1'b1;
      if (byte_valid && byte_ready) idx++;
      @(posedge clk);
      #1;
      if (qam_start) begin nqs++; if (k_qs < 0) k_qs = k; end
      if (done_o) begin ndone++; if (k_done < 0) k_done = k; end
      if (sym_valid) begin nsym++; last_k = k; end
      if (k == gap_k) chk($sformatf("%s bubble_sym_valid", tag), int'(sym_valid), 0);
      if (k == kill_k) begin
        chk($sformatf("%s kill_sym_valid", tag), int'(sym_valid), 0);
        chk($sformatf("%s kill_busy", tag), int'(busy), 0);
        chk($sformatf("%s kill_byte_ready", tag), int'(byte_ready), 0);
        chk($sformatf("%s kill_done", tag), int'(done_o), 0);
        if (kill_rst) begin
          chk($sformatf("%s rst_symbol", tag), int'(symbol), 0);
          chk($sformatf("%s rst_qam_start", tag), int'(qam_start), 0);
        end
      end
      if ((exp_done >= 0) && (k == exp_done)) chk($sformatf("%s busy_at_done", tag), int'(busy), 1);
      if ((exp_done >= 0) && (k == exp_done + 1)) chk($sformatf("%s busy_after_done", tag), int'(busy), 0);
    end
    frame_start = 1'b0; hold_i = 1'b0; frame_abort = 1'b0; rst = 1'b1; byte_valid = 1'b0;
    chk($sformatf("%s qam_start_count", tag), nqs, 1);
    chk($sformatf("%s qam_start_edge", tag), k_qs, 0);
    chk($sformatf("%s done_count", tag), ndone, (exp_done >= 0) ? 1 : 0);
    if (exp_done >= 0) begin
      chk($sformatf("%s done_edge", tag), k_done, exp_done);
      chk($sformatf("%s last_symbol_edge", tag), last_k, exp_done - 1);
    end
    chk($sformatf("%s symbol_count", tag), nsym, exp_nsym);
    chk($sformatf("%s bytes_accepted", tag), idx, exp_bytes);
    chk($sformatf("%s symbols_left", tag), exp_q.size(), 0);
    if (len == 8'd0) chk($sformatf("%s ready_seen", tag), int'(saw_ready), 0);
  endtask

  initial begin
    rst = 1'b0; frame_start = 1'b0; frame_start0 = 1'b0; frame_len = 8'd0;
    frame_abort = 1'b0; byte_data = 8'd0; byte_valid = 1'b0; hold_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset symbol", int'(symbol), 0);
    chk("reset sym_valid", int'(sym_valid), 0);
    chk("reset qam_start", int'(qam_start), 0);
    chk("reset done_o", int'(done_o), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset byte_ready", int'(byte_ready), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    src[0] = 8'h3C; src[1] = 8'h5A;
    push_syms(64'hAAAA3C5A, 8);
    run_frame(8'd2, 2, -1, -1, -1, -1, 1'b0, -1, 10, 8, 2, -1, "basic");

    push_syms(64'hAAAA3C5A, 8);
    run_frame(8'd2, 2, 7, -1, -1, -1, 1'b0, -1, 11, 8, 2, 7, "hold");

    push_syms(64'hAAAA3C5A, 8);
    run_frame(8'd2, 2, -1, 7, 9, -1, 1'b0, -1, 13, 8, 2, 9, "src_gap");

    push_syms(64'hAAAA, 4);
    run_frame(8'd0, 0, -1, -1, -1, -1, 1'b0, -1, 6, 4, 0, -1, "len0");

    push_syms(64'hAAAA3C5, 7);
    run_frame(8'd2, 2, -1, -1, -1, 9, 1'b0, -1, -1, 7, 2, -1, "abort");

    push_syms(64'hAAAA3C5A, 8);
    run_frame(8'd2, 2, -1, -1, -1, -1, 1'b0, 4, 10, 8, 2, -1, "midstart");

    push_syms(64'hAAAA3, 5);
    run_frame(8'd2, 2, -1, -1, -1, 7, 1'b1, -1, -1, 5, 1, -1, "midreset");

    src[0] = 8'hF0; src[1] = 8'h12; src[2] = 8'h8E;
    push_syms(64'hAAAAF0128E, 10);
    run_frame(8'd3, 3, -1, -1, -1, -1, 1'b0, -1, 12, 10, 3, -1, "after_reset");

    // No-preamble, no-payload instance: START -> DONE -> done_o.
    frame_len = 8'd0;
    frame_start0 = 1'b1;
    @(posedge clk);
    #1;
    frame_start0 = 1'b0;
    chk("p0 qam_start", int'(qam_start0), 1);
    chk("p0 busy", int'(busy0), 1);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("p0 done_o k%0d", k), int'(done_o0), (k == 2) ? 1 : 0);
      chk($sformatf("p0 byte_ready k%0d", k), int'(byte_ready0), 0);
      chk($sformatf("p0 sym_valid k%0d", k), int'(sym_valid0) + int'(symbol0), 0);
    end
    chk("p0 busy_after", int'(busy0), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
